// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub/logic, iterative shifts and a shift-add
// unsigned multiplier behind a Start/Done handshake with registered results and flags.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [5:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic [15:0]      Flags
);
    localparam int M  = WIDTH - 1;
    localparam int CW = SHW + 1;

    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_ADDC = 6'd1;
    localparam logic [5:0] ALU_SUB  = 6'd2;
    localparam logic [5:0] ALU_SUBC = 6'd3;
    localparam logic [5:0] ALU_AND  = 6'd4;
    localparam logic [5:0] ALU_OR   = 6'd5;
    localparam logic [5:0] ALU_XOR  = 6'd6;
    localparam logic [5:0] ALU_SHL  = 6'd7;
    localparam logic [5:0] ALU_SHR  = 6'd8;
    localparam logic [5:0] ALU_ASR  = 6'd9;
    localparam logic [5:0] ALU_MUL  = 6'd10;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state;
    logic [5:0]       opr;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    logic [3:0]       flg;

    logic [WIDTH-1:0] add_x, add_y;
    logic             add_c;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res1;
    logic [3:0]       flg1;
    logic             known, fv, fc;
    logic [SHW-1:0]   samt;
    logic             op_shift;
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;
    logic [WIDTH:0]   madd;
    logic [WIDTH-1:0] mlo;

    assign Flags    = {{12{1'b0}}, flg};
    assign samt     = B[SHW-1:0];
    assign op_shift = (Op == ALU_SHL) || (Op == ALU_SHR) || (Op == ALU_ASR);

    // The one adder serves add/sub at accept time and the multiplier partial sums in EXEC.
    always_comb begin
        add_x = A;
        add_y = B;
        add_c = 1'b0;
        if (state == EXEC) begin
            add_x = acc;
            add_y = areg;
        end else begin
            case (Op)
                ALU_ADDC: add_c = CI;
                ALU_SUB:  begin add_y = ~B; add_c = 1'b1; end
                ALU_SUBC: begin add_y = ~B; add_c = CI;   end
                default:  ;
            endcase
        end
        sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_c};
    end

    always_comb begin
        res1  = '0;
        known = 1'b1;
        fv    = 1'b0;
        fc    = 1'b0;
        case (Op)
            ALU_ADD, ALU_ADDC: begin
                res1 = sum[M:0];
                fc   = sum[WIDTH];
                fv   = (A[M] == B[M]) && (sum[M] != A[M]);
            end
            ALU_SUB, ALU_SUBC: begin
                res1 = sum[M:0];
                fc   = sum[WIDTH];
                fv   = (A[M] != B[M]) && (sum[M] != A[M]);
            end
            ALU_AND: res1 = A & B;
            ALU_OR:  res1 = A | B;
            ALU_XOR: res1 = A ^ B;
            ALU_SHL, ALU_SHR, ALU_ASR: res1 = A;
            default: known = 1'b0;
        endcase
        flg1 = known ? {res1[M], res1 == '0, fv, fc} : 4'b0000;
    end

    always_comb begin
        sh_next = sh;
        sh_out  = 1'b0;
        case (opr)
            ALU_SHL: begin sh_next = {sh[M-1:0], 1'b0}; sh_out = sh[M]; end
            ALU_SHR: begin sh_next = {1'b0, sh[M:1]};   sh_out = sh[0]; end
            ALU_ASR: begin sh_next = {sh[M], sh[M:1]};  sh_out = sh[0]; end
            default: ;
        endcase
        madd = sh[0] ? sum : {1'b0, acc};
        mlo  = {madd[0], sh[M:1]};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Result   <= '0;
            ResultHi <= '0;
            flg      <= '0;
            opr      <= '0;
            areg     <= '0;
            acc      <= '0;
            sh       <= '0;
            cnt      <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (Start) begin
                        opr  <= Op;
                        areg <= A;
                        acc  <= '0;
                        if (Op == ALU_MUL) begin
                            sh    <= B;
                            cnt   <= CW'(WIDTH);
                            Busy  <= 1'b1;
                            state <= EXEC;
                        end else if (op_shift && samt != '0) begin
                            sh    <= A;
                            cnt   <= {1'b0, samt};
                            Busy  <= 1'b1;
                            state <= EXEC;
                        end else begin
                            Result   <= res1;
                            ResultHi <= '0;
                            flg      <= flg1;
                            Done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt - CW'(1);
                    if (opr == ALU_MUL) begin
                        // {acc,sh} holds the partial product; its low half shifts out the multiplier bits.
                        acc <= madd[WIDTH:1];
                        sh  <= mlo;
                        if (cnt == CW'(1)) begin
                            Result   <= mlo;
                            ResultHi <= madd[WIDTH:1];
                            flg      <= {madd[WIDTH], {madd[WIDTH:1], mlo} == '0,
                                         madd[WIDTH:1] != '0, 1'b0};
                        end
                    end else begin
                        sh <= sh_next;
                        if (cnt == CW'(1)) begin
                            Result   <= sh_next;
                            ResultHi <= '0;
                            flg      <= {sh_next[M], sh_next == '0, 1'b0, sh_out};
                        end
                    end
                    if (cnt == CW'(1)) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
